// File: rtl/tdc_readout_pkg.sv
// Shared definitions for the TDC result-buffer SPI readout block.
// Contents:
//   WORD_W_DEF     default SPI word width (matches the result buffer output width)
//   EMPTY_WORD_DEF word shifted out when the buffer has nothing unread
//   rd_state_t     readout FSM state encoding
package tdc_readout_pkg;

    localparam int unsigned WORD_W_DEF = 24;
    localparam logic [WORD_W_DEF-1:0] EMPTY_WORD_DEF = 24'h000000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        ADVANCE,
        WAIT
    } rd_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes one asynchronous SPI pad input into the system clock domain and
// flags its edges.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset
//   d_i      asynchronous input (SCK or CSN)
//   level_o  synchronized level
//   rise_o   1-clk pulse on a synchronized 0->1 transition
//   fall_o   1-clk pulse on a synchronized 1->0 transition
// SYNC_STAGES must be at least 2. RESET_VAL is the idle level of the pad, so that
// releasing reset never produces a spurious edge.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/tdc_spi_readout.sv
// SPI slave transmitter (mode 0, MSB first) draining the calibrated TDC result
// buffer to the external host. SCK and CSN are oversampled in the system clock
// domain (clk must run at least 8x SCK), so the whole block is single-clock.
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   spi_sck         host SPI clock (async, CPOL=0)
//   spi_csn         host chip select (async, active-low)
//   spi_miso        serial data to host
//   spi_miso_oe     pad output enable, high while a frame is active
//   buf_data        current buffer word {data[18:0], onum[2:0], tag[1:0]}
//   buf_int         buffer holds unread results
//   buf_read_done   buffer has delivered its last word
//   odstart         1-clk pulse: word consumed, advance the buffer read pointer
//   read_en         high while a frame is active
//   frame_words     words fully sent in the current/last frame (saturating)
module tdc_spi_readout
    import tdc_readout_pkg::*;
#(
    parameter int unsigned       WORD_W      = WORD_W_DEF,
    parameter int unsigned       SYNC_STAGES = 2,
    parameter logic [WORD_W-1:0] EMPTY_WORD  = WORD_W'(EMPTY_WORD_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sck,
    input  logic              spi_csn,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic [WORD_W-1:0] buf_data,
    input  logic              buf_int,
    input  logic              buf_read_done,
    output logic              odstart,
    output logic              read_en,
    output logic [7:0]        frame_words
);

    localparam int unsigned       CntW    = $clog2(WORD_W + 1);
    localparam logic [CntW-1:0]   LastBit = CntW'(WORD_W - 1);

    logic sck_level_unused;
    logic sck_rise;
    logic sck_fall;
    logic csn_s;
    logic csn_rise_unused;
    logic csn_fall;

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b0)
    ) u_sync_sck (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (spi_sck),
        .level_o(sck_level_unused),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .RESET_VAL  (1'b1)
    ) u_sync_csn (
        .clk_i  (clk),
        .rst_i  (rst),
        .d_i    (spi_csn),
        .level_o(csn_s),
        .rise_o (csn_rise_unused),
        .fall_o (csn_fall)
    );

    rd_state_t         state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic              was_valid_q, was_valid_d;
    logic [CntW-1:0]   bitcnt_q, bitcnt_d;
    logic              miso_q, miso_d;
    logic [7:0]        frame_words_q, frame_words_d;
    logic              word_valid;

    // The buffer drops buf_int once read_done is up; gating on both keeps a stale
    // word from being re-sent if the two flags ever disagree for a cycle.
    assign word_valid = buf_int & ~buf_read_done;

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        was_valid_d   = was_valid_q;
        bitcnt_d      = bitcnt_q;
        miso_d        = miso_q;
        frame_words_d = frame_words_q;

        unique case (state_q)
            IDLE: begin
                bitcnt_d = '0;
                miso_d   = 1'b0;
                if (csn_fall) begin
                    frame_words_d = '0;
                    state_d       = LOAD;
                end
            end
            LOAD: begin
                shreg_d     = word_valid ? buf_data : EMPTY_WORD;
                was_valid_d = word_valid;
                miso_d      = shreg_d[WORD_W-1];
                // bitcnt was cleared on leaving SHIFT; a premature host rise seen
                // between words is carried into this word rather than dropped.
                bitcnt_d    = bitcnt_q + CntW'(sck_rise);
                state_d     = csn_s ? IDLE : SHIFT;
            end
            SHIFT: begin
                if (sck_rise) begin
                    if (bitcnt_q == LastBit) begin
                        bitcnt_d = '0;
                        state_d  = ADVANCE;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end else if (sck_fall && bitcnt_q != '0) begin
                    // The fall trailing the previous word's last rise arrives with
                    // bitcnt still 0; the freshly loaded MSB must stay on the pin.
                    shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
                    miso_d  = shreg_q[WORD_W-2];
                end
                // A CSN rise coinciding with the final rise still completes the word.
                if (csn_s && state_d != ADVANCE) begin
                    state_d = IDLE;
                end
            end
            ADVANCE: begin
                if (frame_words_q != 8'hFF) begin
                    frame_words_d = frame_words_q + 8'd1;
                end
                bitcnt_d = bitcnt_q + CntW'(sck_rise);
                state_d  = csn_s ? IDLE : WAIT;
            end
            WAIT: begin
                bitcnt_d = bitcnt_q + CntW'(sck_rise);
                state_d  = csn_s ? IDLE : LOAD;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            shreg_q       <= '0;
            was_valid_q   <= 1'b0;
            bitcnt_q      <= '0;
            miso_q        <= 1'b0;
            frame_words_q <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            was_valid_q   <= was_valid_d;
            bitcnt_q      <= bitcnt_d;
            miso_q        <= miso_d;
            frame_words_q <= frame_words_d;
        end
    end

    assign read_en     = (state_q != IDLE);
    assign spi_miso_oe = read_en;
    assign spi_miso    = miso_q & read_en;
    assign odstart     = (state_q == ADVANCE) & was_valid_q;
    assign frame_words = frame_words_q;

endmodule
